// File: rtl/ped_button_conditioner.sv
// Pedestrian push-button front end: synchronise, debounce, edge-detect, then hold a
// request until walk is served, followed by a cooldown that drops any new press.
module ped_button_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int COOLDOWN_CYCLES = 32,
  parameter int CNT_W           = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       button_raw,
  input  logic       walk,
  output logic       ped_request,
  output logic       btn_stable,
  output logic [7:0] press_count
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    SERVE    = 2'd2,
    COOLDOWN = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CD_LOAD = CNT_W'(COOLDOWN_CYCLES - 1);
  localparam logic [7:0]       CNT_MAX = 8'hFF;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   btn_sync;

  logic                   stable_q, stable_d;
  logic                   stable_dly_q, stable_dly_d;
  logic [CNT_W-1:0]       db_cnt_q, db_cnt_d;

  logic                   press_q, press_d;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cd_cnt_q, cd_cnt_d;
  logic [7:0]             press_count_q, press_count_d;

  // Synchroniser: oldest stage is the only one the rest of the design looks at.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], button_raw};
  end

  assign btn_sync = sync_q[SYNC_STAGES-1];

  // Debounce: a level change is accepted only after DEBOUNCE_CYCLES disagreeing edges.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
    stable_d = stable_q;
    db_cnt_d = '0;
    if (btn_sync != stable_q) begin
      if (db_cnt_q == DB_LAST) begin
        stable_d = btn_sync;
      end else begin
        db_cnt_d = db_cnt_q + CNT_W'(1);
      end
    end
  end

  // One-cycle press pulse on the edge after the debounced level rises.
  always_comb begin
    stable_dly_d = stable_q;
    press_d      = stable_q & ~stable_dly_q;
  end

  always_comb begin
    state_d       = state_q;
    cd_cnt_d      = cd_cnt_q;
    press_count_d = press_count_q;
    unique case (state_q)
      IDLE: begin
        if (press_q) begin
          state_d = REQ;
          if (press_count_q != CNT_MAX) begin
            press_count_d = press_count_q + 8'd1;
          end
        end
      end
      REQ: begin
        if (walk) begin
          state_d = SERVE;
        end
      end
      SERVE: begin
        if (!walk) begin
          state_d  = COOLDOWN;
          cd_cnt_d = CD_LOAD;
        end
      end
      COOLDOWN: begin
        // A press landing on the expiry edge is dropped because IDLE is not yet current.
        if (cd_cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cd_cnt_d = cd_cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q        <= '0;
      stable_q      <= 1'b0;
      stable_dly_q  <= 1'b0;
      db_cnt_q      <= '0;
      press_q       <= 1'b0;
      state_q       <= IDLE;
      cd_cnt_q      <= '0;
      press_count_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge value of the others.
      sync_q        <= sync_d;
      stable_q      <= stable_d;
      stable_dly_q  <= stable_dly_d;
      db_cnt_q      <= db_cnt_d;
      press_q       <= press_d;
      state_q       <= state_d;
      cd_cnt_q      <= cd_cnt_d;
      press_count_q <= press_count_d;
    end
  end

  assign ped_request = (state_q == REQ);
  assign btn_stable  = stable_q;
  assign press_count = press_count_q;

endmodule

// File: tb/tb_ped_button_conditioner.sv
// Self-checking bench for ped_button_conditioner: directed scenarios plus random
// stimulus, all compared against an event/timestamp-based reference model.
module tb_ped_button_conditioner;

  localparam int SYNC  = 2;
  localparam int DEB   = 16;
  localparam int COOL  = 32;
  localparam int HALF  = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       button_raw = 1'b0;
  logic       walk = 1'b0;
  logic       ped_request;
  logic       btn_stable;
  logic [7:0] press_count;

  int n_checks = 0;
  int n_pass   = 0;

  ped_button_conditioner #(
    .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .COOLDOWN_CYCLES(COOL), .CNT_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .button_raw(button_raw), .walk(walk),
    .ped_request(ped_request), .btn_stable(btn_stable), .press_count(press_count)
  );

  always #HALF clk = ~clk;

  // Reference model: raw history, disagreement run length, scheduled press
  // deliveries (edge numbers) and a phase with a cooldown deadline.
  typedef enum int {M_IDLE, M_WAITING, M_WALKING, M_COOLING} mphase_e;

  bit      m_hist[$];
  int      m_run;
  bit      m_stable;
  int      m_due[$];
  mphase_e m_phase;
  int      m_cool_until;
  int      m_count;
  int      cyc = 0;

  function automatic void m_reset();
    m_hist.delete();
    for (int i = 0; i < SYNC; i++) m_hist.push_back(1'b0);
    m_run    = 0;
    m_stable = 1'b0;
    m_due.delete();
    m_phase  = M_IDLE;
    m_count  = 0;
    m_cool_until = 0;
  endfunction

  function automatic void model_edge(bit raw, bit w);
    bit bsync;
    bit press_now;
    cyc++;
    bsync = m_hist[SYNC-1];
    m_hist.push_front(raw);
    void'(m_hist.pop_back());
    press_now = 1'b0;
    if (m_due.size() > 0 && m_due[0] == cyc) begin
      press_now = 1'b1;
      void'(m_due.pop_front());
    end
    if (bsync != m_stable) begin
      m_run++;
      if (m_run == DEB) begin
        m_stable = bsync;
        m_run    = 0;
        if (m_stable) m_due.push_back(cyc + 2);
      end
    end else begin
      m_run = 0;
    end
    case (m_phase)
      M_IDLE:    if (press_now) begin
                   m_phase = M_WAITING;
                   if (m_count < 255) m_count++;
                 end
      M_WAITING: if (w) m_phase = M_WALKING;
      M_WALKING: if (!w) begin
                   m_phase = M_COOLING;
                   m_cool_until = cyc + COOL;
                 end
      M_COOLING: if (cyc == m_cool_until) m_phase = M_IDLE;
      default:   m_phase = M_IDLE;
    endcase
  endfunction

  function automatic logic [9:0] model_out();
    return {m_phase == M_WAITING, m_stable, 8'(m_count)};
  endfunction

  // Drive inputs, advance one edge, update the model, land on the falling edge.
  task automatic step(input bit raw, input bit w);
    button_raw = raw;
    walk       = w;
    @(posedge clk);
    if (rst_n) model_edge(raw, w);
    else       m_reset();
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    #1 rst_n = 1'b0;
    m_reset();
    #(HALF - 3) rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [9:0] obs;
    rst_n = 1'b0;
    m_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1);
      obs = {ped_request, btn_stable, press_count};
      n_checks++;
      if (obs !== 10'b0) $display("FAIL reset_state: got %b required %b", obs, 10'b0);
      else n_pass++;
    end
    button_raw = 1'b0;
    walk       = 1'b0;
    #2 rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 30; i++) step(1'b0, 1'b0);
    obs = {ped_request, btn_stable, press_count};
    n_checks++;
    if (obs !== model_out()) $display("FAIL reset_release: got %b required %b", obs, model_out());
    else n_pass++;
  endtask

  task automatic test_bounce();
    logic [9:0] obs;
    for (int i = 0; i < 90; i++) begin
      step((i < 60) ? ((i / 5) % 2 == 0) : 1'b0, 1'b0);
      obs = {ped_request, btn_stable, press_count};
      n_checks++;
      if (obs !== model_out()) $display("FAIL bounce_model step %0d: got %b required %b", i, obs, model_out());
      else n_pass++;
    end
    obs = {ped_request, btn_stable, press_count};
    n_checks++;
    if (obs !== 10'b0) $display("FAIL bounce_ignored: got %b required %b", obs, 10'b0);
    else n_pass++;
  endtask

  task automatic test_clean_press();
    for (int i = 1; i <= 40; i++) begin
      step(1'b1, 1'b0);
      n_checks++;
      if (ped_request !== (i >= 20))
        $display("FAIL press_latency edge %0d: got %b required %b", i, ped_request, (i >= 20));
      else n_pass++;
    end
    for (int i = 0; i < 30; i++) step(1'b0, 1'b0);
    n_checks++;
    if ({ped_request, press_count} !== {1'b1, 8'd1})
      $display("FAIL press_held: got ped=%b count=%0d required ped=1 count=1", ped_request, press_count);
    else n_pass++;
  endtask

  task automatic test_serve_cooldown();
    logic [9:0] obs;
    step(1'b0, 1'b1);
    n_checks++;
    if (ped_request !== 1'b0) $display("FAIL walk_release: got %b required 0", ped_request);
    else n_pass++;
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    for (int i = 0; i < 45; i++) begin
      step(i < 25, 1'b0);
      obs = {ped_request, btn_stable, press_count};
      n_checks++;
      if (obs !== model_out()) $display("FAIL cooldown_model step %0d: got %b required %b", i, obs, model_out());
      else n_pass++;
    end
    n_checks++;
    if ({ped_request, press_count} !== {1'b0, 8'd1})
      $display("FAIL cooldown_drop: got ped=%b count=%0d required ped=0 count=1", ped_request, press_count);
    else n_pass++;
    for (int i = 0; i < 25; i++) step(1'b1, 1'b0);
    n_checks++;
    if ({ped_request, press_count} !== {1'b1, 8'd2})
      $display("FAIL after_cooldown: got ped=%b count=%0d required ped=1 count=2", ped_request, press_count);
    else n_pass++;
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    for (int i = 0; i < 40; i++) step(1'b0, 1'b0);
  endtask

  // Press delivered on the last cooldown edge (offset 12) is dropped; one later is taken.
  task automatic test_cooldown_boundary();
    int base;
    for (int off = 12; off <= 13; off++) begin
      for (int i = 0; i < 22; i++) step(1'b1, 1'b0);
      for (int i = 0; i < 22; i++) step(1'b0, 1'b0);
      step(1'b0, 1'b1);
      step(1'b0, 1'b0);
      base = int'(press_count);
      for (int i = 0; i < off; i++) step(1'b0, 1'b0);
      for (int i = 0; i < 30; i++) step(1'b1, 1'b0);
      n_checks++;
      if ({ped_request, press_count} !== {off == 13, 8'(base + ((off == 13) ? 1 : 0))})
        $display("FAIL boundary off=%0d: got ped=%b count=%0d required ped=%b count=%0d",
                 off, ped_request, press_count, off == 13, base + ((off == 13) ? 1 : 0));
      else n_pass++;
      n_checks++;
      if ({ped_request, btn_stable, press_count} !== model_out())
        $display("FAIL boundary_model off=%0d: got %b required %b", off,
                 {ped_request, btn_stable, press_count}, model_out());
      else n_pass++;
      for (int i = 0; i < 25; i++) step(1'b0, 1'b0);
    end
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    for (int i = 0; i < 40; i++) step(1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_req();
    pulse_reset();
    for (int i = 0; i < 22; i++) step(1'b1, 1'b0);
    n_checks++;
    if (ped_request !== 1'b1) $display("FAIL mid_req_setup: got %b required 1", ped_request);
    else n_pass++;
    #1 rst_n = 1'b0;
    m_reset();
    #1;
    n_checks++;
    if ({ped_request, btn_stable, press_count} !== 10'b0)
      $display("FAIL async_drop: got %b required %b", {ped_request, btn_stable, press_count}, 10'b0);
    else n_pass++;
    #(HALF - 3) rst_n = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step(1'b1, 1'b0);
      n_checks++;
      if (ped_request !== (i >= 20))
        $display("FAIL re_debounce edge %0d: got %b required %b", i, ped_request, (i >= 20));
      else n_pass++;
    end
    n_checks++;
    if (press_count !== 8'd1) $display("FAIL mid_req_count: got %0d required 1", press_count);
    else n_pass++;
    for (int i = 0; i < 22; i++) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    for (int i = 0; i < 40; i++) step(1'b0, 1'b0);
  endtask

  task automatic test_random();
    bit raw_lvl;
    bit w;
    int len;
    int steps = 0;
    logic [9:0] obs;
    while (steps < 1500) begin
      raw_lvl = 1'($urandom_range(0, 1));
      w       = ($urandom_range(0, 3) == 0);
      len     = $urandom_range(1, 30);
      for (int i = 0; i < len; i++) begin
        step(raw_lvl, w);
        steps++;
        obs = {ped_request, btn_stable, press_count};
        n_checks++;
        if (obs !== model_out())
          $display("FAIL random_model step %0d: got %b required %b", steps, obs, model_out());
        else n_pass++;
      end
    end
  endtask

  task automatic test_saturation();
    logic [9:0] obs;
    pulse_reset();
    for (int r = 0; r < 300; r++) begin
      for (int i = 0; i < 22; i++) step(1'b1, 1'b0);
      for (int i = 0; i < $urandom_range(1, 3); i++) step(1'b0, 1'b1);
      for (int i = 0; i < 40; i++) step(1'b0, 1'b0);
      obs = {ped_request, btn_stable, press_count};
      n_checks++;
      if (obs !== model_out()) $display("FAIL sat_round %0d: got %b required %b", r, obs, model_out());
      else n_pass++;
    end
    n_checks++;
    if (press_count !== 8'd255) $display("FAIL saturation: got %0d required 255", press_count);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_clean_press();
    test_serve_cooldown();
    test_cooldown_boundary();
    test_reset_mid_req();
    test_random();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
